// File: rtl/ss_sg2.sv
// ss_sg2: scatter-gather engine for the ss_adma datapath.
// Walks a linked list of 8-byte-aligned descriptors over a 64-bit Wishbone
// master and streams buffer beats to or from the FIFO side. Descriptor word 0
// holds the buffer address (low word) and {last, len} (high word); word 1
// holds the next descriptor pointer in its high word.
module ss_sg2 #(
  parameter int RW        = 0,
  parameter int LENW      = 16,
  parameter int MAX_BURST = 16,
  parameter int RTY_MAX   = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic        wbs_cyc,
  output logic        wbs_stb,
  output logic        wbs_we,
  output logic        wbs_cab,
  output logic [3:0]  wbs_sel,
  output logic [31:0] wbs_adr,
  input  logic [31:0] wbs_dat_o,
  input  logic [31:0] wbs_dat64_o,
  input  logic        wbs_ack,
  input  logic        wbs_err,
  input  logic        wbs_rty,
  input  logic [31:0] ss_dat,
  input  logic        ss_we,
  input  logic [1:0]  ss_adr,
  input  logic        ss_done,
  input  logic        ss_abort,
  input  logic        ss_ready,
  output logic        ss_xfer,
  output logic [7:0]  sg_state,
  output logic [15:0] sg_desc,
  output logic [28:0] sg_addr,
  output logic [28:0] sg_next,
  output logic [2:0]  sg_err,
  output logic        c_done,
  output logic        c_panic
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_D_REQ  = 3'd2;
  localparam logic [2:0] S_B_REQ  = 3'd3;
  localparam logic [2:0] S_B_WAIT = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_END    = 3'd6;
  localparam logic [2:0] S_PANIC  = 3'd7;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_DESC  = 3'd1;
  localparam logic [2:0] E_BUF   = 3'd2;
  localparam logic [2:0] E_RTY   = 3'd3;
  localparam logic [2:0] E_ABORT = 3'd4;

  localparam logic [LENW-1:0] LEN_ZERO = {LENW{1'b0}};
  localparam logic [LENW-1:0] LEN_ONE  = {{(LENW-1){1'b0}}, 1'b1};
  localparam logic [7:0]      RTY_LIM  = 8'(RTY_MAX);
  localparam logic [7:0]      BURST_LIM = 8'(MAX_BURST);
  localparam logic            WE_DIR   = (RW != 0) ? 1'b1 : 1'b0;

  logic [2:0]      state_r, state_nxt_s;
  logic            cyc_r, cyc_nxt_s;
  logic            we_r, we_nxt_s;
  logic [3:0]      sel_r, sel_nxt_s;
  logic [28:0]     adr_r, adr_nxt_s;
  logic [2:0]      err_r, err_nxt_s;
  logic [LENW-1:0] len_r, len_nxt_s;
  logic [28:0]     addr_r, addr_nxt_s;
  logic [28:0]     next_r, next_nxt_s;
  logic            last_r, last_nxt_s;
  logic [23:0]     dc_fc_r, dc_fc_nxt_s;
  logic            beat_r, beat_nxt_s;
  logic [7:0]      burst_r, burst_nxt_s;
  logic            io_r, io_nxt_s;
  logic [7:0]      rty_r, rty_nxt_s;

  logic            abort_act_s;
  logic [7:0]      rty_inc_s;
  logic            rty_hit_s;
  logic [7:0]      burst_inc_s;
  logic            burst_end_s;
  logic            len_one_s;
  logic [27:0]     len_ext_s;
  logic            unused_s;

  assign abort_act_s = ss_abort && ((state_r == S_CMD) || (state_r == S_D_REQ) ||
                                    (state_r == S_B_REQ) || (state_r == S_B_WAIT) ||
                                    (state_r == S_NEXT));
  assign rty_inc_s   = rty_r + 8'd1;
  assign rty_hit_s   = (rty_inc_s == RTY_LIM);
  assign burst_inc_s = burst_r + 8'd1;
  assign burst_end_s = (burst_inc_s == BURST_LIM);
  assign len_one_s   = (len_r == LEN_ONE);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision; bus response priority is err > ack > rty, abort first.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (ss_we) state_nxt_s = S_CMD;
        else       state_nxt_s = S_IDLE;
      end
      S_CMD: begin
        if (abort_act_s)                    state_nxt_s = S_PANIC;
        else if (ss_we && ss_adr == 2'd3)   state_nxt_s = S_NEXT;
        else                                state_nxt_s = S_CMD;
      end
      S_NEXT: begin
        if (abort_act_s)  state_nxt_s = S_PANIC;
        else if (last_r)  state_nxt_s = S_END;
        else              state_nxt_s = S_D_REQ;
      end
      S_D_REQ: begin
        if (abort_act_s)       state_nxt_s = S_PANIC;
        else if (wbs_err)      state_nxt_s = S_PANIC;
        else if (wbs_ack) begin
          if (!beat_r)                state_nxt_s = S_D_REQ;
          else if (len_r == LEN_ZERO) state_nxt_s = S_NEXT;
          else                        state_nxt_s = S_B_WAIT;
        end else if (wbs_rty) begin
          if (rty_hit_s) state_nxt_s = S_PANIC;
          else           state_nxt_s = S_D_REQ;
        end else begin
          state_nxt_s = S_D_REQ;
        end
      end
      S_B_WAIT: begin
        if (abort_act_s)   state_nxt_s = S_PANIC;
        else if (ss_ready) state_nxt_s = S_B_REQ;
        else               state_nxt_s = S_B_WAIT;
      end
      S_B_REQ: begin
        if (abort_act_s)       state_nxt_s = S_PANIC;
        else if (wbs_err)      state_nxt_s = S_PANIC;
        else if (wbs_ack) begin
          if (len_one_s)                     state_nxt_s = S_NEXT;
          else if (!ss_ready || burst_end_s) state_nxt_s = S_B_WAIT;
          else                               state_nxt_s = S_B_REQ;
        end else if (wbs_rty) begin
          if (io_r)           state_nxt_s = S_B_WAIT;
          else if (rty_hit_s) state_nxt_s = S_PANIC;
          else                state_nxt_s = S_B_REQ;
        end else begin
          state_nxt_s = S_B_REQ;
        end
      end
      S_END, S_PANIC: begin
        if (ss_done) state_nxt_s = S_IDLE;
        else         state_nxt_s = state_r;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Datapath and bus-request next values, mirroring the state decisions above.
  always_comb begin
    cyc_nxt_s   = cyc_r;
    we_nxt_s    = we_r;
    sel_nxt_s   = sel_r;
    adr_nxt_s   = adr_r;
    err_nxt_s   = err_r;
    len_nxt_s   = len_r;
    addr_nxt_s  = addr_r;
    next_nxt_s  = next_r;
    last_nxt_s  = last_r;
    dc_fc_nxt_s = dc_fc_r;
    beat_nxt_s  = beat_r;
    burst_nxt_s = burst_r;
    io_nxt_s    = io_r;
    rty_nxt_s   = rty_r;
    if (abort_act_s) begin
      cyc_nxt_s = 1'b0;
      err_nxt_s = E_ABORT;
    end else begin
      case (state_r)
        S_CMD: begin
          if (ss_we) begin
            case (ss_adr)
              2'd1:    dc_fc_nxt_s = ss_dat[23:0];
              2'd2:    next_nxt_s  = ss_dat[31:3];
              2'd3: begin
                last_nxt_s = 1'b0;
                err_nxt_s  = E_NONE;
              end
              default: dc_fc_nxt_s = dc_fc_r;
            endcase
          end else begin
            dc_fc_nxt_s = dc_fc_r;
          end
        end
        S_NEXT: begin
          if (!last_r) begin
            adr_nxt_s  = next_r;
            cyc_nxt_s  = 1'b1;
            we_nxt_s   = 1'b0;
            sel_nxt_s  = 4'hF;
            beat_nxt_s = 1'b0;
            rty_nxt_s  = 8'd0;
          end else begin
            cyc_nxt_s = 1'b0;
          end
        end
        S_D_REQ: begin
          if (wbs_err) begin
            cyc_nxt_s = 1'b0;
            err_nxt_s = E_DESC;
          end else if (wbs_ack) begin
            if (!beat_r) begin
              addr_nxt_s = wbs_dat_o[31:3];
              len_nxt_s  = wbs_dat64_o[LENW+2:3];
              last_nxt_s = wbs_dat64_o[20];
              beat_nxt_s = 1'b1;
              adr_nxt_s  = adr_r + 29'd1;
            end else begin
              next_nxt_s = wbs_dat64_o[31:3];
              cyc_nxt_s  = 1'b0;
            end
          end else if (wbs_rty) begin
            rty_nxt_s = rty_inc_s;
            if (rty_hit_s) begin
              cyc_nxt_s = 1'b0;
              err_nxt_s = E_RTY;
            end else begin
              cyc_nxt_s = 1'b1;
            end
          end else begin
            cyc_nxt_s = cyc_r;
          end
        end
        S_B_WAIT: begin
          if (ss_ready) begin
            adr_nxt_s   = addr_r;
            cyc_nxt_s   = 1'b1;
            we_nxt_s    = WE_DIR;
            sel_nxt_s   = 4'hF;
            burst_nxt_s = 8'd0;
            io_nxt_s    = 1'b0;
            rty_nxt_s   = 8'd0;
          end else begin
            cyc_nxt_s = 1'b0;
          end
        end
        S_B_REQ: begin
          if (wbs_err) begin
            cyc_nxt_s = 1'b0;
            err_nxt_s = E_BUF;
          end else if (wbs_ack) begin
            addr_nxt_s  = addr_r + 29'd1;
            adr_nxt_s   = addr_r + 29'd1;
            len_nxt_s   = len_r - LEN_ONE;
            burst_nxt_s = burst_inc_s;
            io_nxt_s    = 1'b1;
            rty_nxt_s   = 8'd0;
            if (len_one_s || !ss_ready || burst_end_s) cyc_nxt_s = 1'b0;
            else                                       cyc_nxt_s = 1'b1;
          end else if (wbs_rty) begin
            if (io_r) begin
              cyc_nxt_s = 1'b0;
            end else begin
              rty_nxt_s = rty_inc_s;
              if (rty_hit_s) begin
                cyc_nxt_s = 1'b0;
                err_nxt_s = E_RTY;
              end else begin
                cyc_nxt_s = 1'b1;
              end
            end
          end else begin
            cyc_nxt_s = cyc_r;
          end
        end
        default: cyc_nxt_s = cyc_r;
      endcase
    end
  end

  // Datapath and Wishbone output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cyc_r   <= 1'b0;
      we_r    <= 1'b0;
      sel_r   <= 4'h0;
      adr_r   <= 29'd0;
      err_r   <= E_NONE;
      len_r   <= LEN_ZERO;
      addr_r  <= 29'd0;
      next_r  <= 29'd0;
      last_r  <= 1'b0;
      dc_fc_r <= 24'd0;
      beat_r  <= 1'b0;
      burst_r <= 8'd0;
      io_r    <= 1'b0;
      rty_r   <= 8'd0;
    end else begin
      cyc_r   <= cyc_nxt_s;
      we_r    <= we_nxt_s;
      sel_r   <= sel_nxt_s;
      adr_r   <= adr_nxt_s;
      err_r   <= err_nxt_s;
      len_r   <= len_nxt_s;
      addr_r  <= addr_nxt_s;
      next_r  <= next_nxt_s;
      last_r  <= last_nxt_s;
      dc_fc_r <= dc_fc_nxt_s;
      beat_r  <= beat_nxt_s;
      burst_r <= burst_nxt_s;
      io_r    <= io_nxt_s;
      rty_r   <= rty_nxt_s;
    end
  end

  // Output decode: strobe follows cycle, burst hint is constant while in a cycle.
  assign wbs_cyc   = cyc_r;
  assign wbs_stb   = cyc_r;
  assign wbs_cab   = cyc_r;
  assign wbs_we    = we_r;
  assign wbs_sel   = sel_r;
  assign wbs_adr   = {adr_r, 3'b000};
  assign ss_xfer   = (state_r == S_B_REQ) && wbs_ack && !wbs_err && !ss_abort;
  assign sg_state  = {last_r, err_r, 1'b0, state_r};
  assign len_ext_s = 28'(len_r);
  assign sg_desc   = len_ext_s[15:0];
  assign sg_addr   = addr_r;
  assign sg_next   = next_r;
  assign sg_err    = err_r;
  assign c_done    = (state_r == S_END);
  assign c_panic   = (state_r == S_PANIC);

  // Transfer-count word and descriptor bits outside the decoded fields are not consumed.
  assign unused_s  = ^{dc_fc_r, wbs_dat_o, wbs_dat64_o, len_ext_s};

endmodule
